// File: rtl/cpu_sram_like_bridge_pkg.sv
// Shared types for the cpu_sram_like_bridge slice: FSM state encoding, bus size codes
// and the byte-strobe to transfer-size mapping.
package cpu_sram_like_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_REQ  = 3'd1,
        ST_D_WAIT = 3'd2,
        ST_I_REQ  = 3'd3,
        ST_I_WAIT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int POSTED_MAX_DEFAULT = 3;

    // Irregular strobe patterns fall back to a word access carrying the raw strobes.
    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0011, 4'b1100:                   size = SZ_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SZ_BYTE;
            default:                            size = SZ_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/bridge_req_mux.sv
// Combinational request-field selection for the shared bus: data access vs fetch,
// with size/strobe derivation. All fields are forced to zero when no request is active.
module bridge_req_mux
    import cpu_sram_like_bridge_pkg::*;
(
    input  logic        active,
    input  logic        sel_data,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [31:0] inst_addr,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata
);

    always_comb begin
        bus_wr    = 1'b0;
        bus_size  = SZ_BYTE;
        bus_wstrb = 4'b0000;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        if (active) begin
            if (sel_data) begin
                bus_addr = data_addr;
                bus_size = SZ_WORD;
                if (data_wen != 4'b0000) begin
                    bus_wr    = 1'b1;
                    bus_size  = wen_to_size(data_wen);
                    bus_wstrb = data_wen;
                    bus_wdata = data_wdata;
                end
            end else begin
                bus_addr = inst_addr;
                bus_size = SZ_WORD;
            end
        end
    end

endmodule

// File: rtl/cpu_sram_like_bridge.sv
// Serialises the core's fetch and data sram ports onto one sram-like bus, data first.
// Optional macro BRIDGE_POSTED_WRITE_EN: data writes complete on addr_ok (posted).
module cpu_sram_like_bridge
    import cpu_sram_like_bridge_pkg::*;
#(
    parameter int POSTED_MAX = POSTED_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stall_req,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    state_t      state_reg, state_next;
    logic        i_en_reg;
    logic [31:0] i_addr_reg;
    logic [3:0]  d_wen_reg;
    logic [31:0] d_addr_reg;
    logic [31:0] d_wdata_reg;
    logic [31:0] inst_rdata_reg;
    logic [31:0] data_rdata_reg;

    logic        capture;
    logic        d_is_write;
    logic        req;
    logic        sel_data;
    logic        d_blocked;
    logic        i_blocked;

    // Fetch port write fields are never used: fetch is read-only.
    logic        unused_inst_fields;
    assign unused_inst_fields = ^{inst_sram_wen, inst_sram_wdata};

    assign capture    = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign d_is_write = (d_wen_reg != 4'b0000);

`ifdef BRIDGE_POSTED_WRITE_EN
    logic [1:0] posted_reg, posted_next;
    logic       posted_inc, posted_dec;

    // Reads wait for all posted acks so every data_ok in a WAIT state is unambiguous.
    assign d_blocked  = d_is_write ? (posted_reg == 2'(POSTED_MAX)) : (posted_reg != 2'd0);
    assign i_blocked  = (posted_reg != 2'd0);
    assign posted_dec = bus_data_ok && (posted_reg != 2'd0) &&
                        (state_reg != ST_D_WAIT) && (state_reg != ST_I_WAIT);

    always_comb begin
        posted_next = posted_reg;
        case ({posted_inc, posted_dec})
            2'b10:   posted_next = posted_reg + 2'd1;
            2'b01:   posted_next = posted_reg - 2'd1;
            default: posted_next = posted_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            posted_reg <= 2'd0;
        end else begin
            posted_reg <= posted_next;
        end
    end
`else
    localparam int unused_posted_max = POSTED_MAX;
    assign d_blocked = 1'b0;
    assign i_blocked = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        req        = 1'b0;
        sel_data   = 1'b0;
`ifdef BRIDGE_POSTED_WRITE_EN
        posted_inc = 1'b0;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (data_sram_en) begin
                    state_next = ST_D_REQ;
                end else if (inst_sram_en) begin
                    state_next = ST_I_REQ;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_D_REQ: begin
                sel_data = 1'b1;
                req      = !d_blocked;
                if (req && bus_addr_ok) begin
`ifdef BRIDGE_POSTED_WRITE_EN
                    if (d_is_write) begin
                        posted_inc = 1'b1;
                        state_next = i_en_reg ? ST_I_REQ : ST_DONE;
                    end else begin
                        state_next = ST_D_WAIT;
                    end
`else
                    state_next = ST_D_WAIT;
`endif
                end
            end
            ST_D_WAIT: begin
                if (bus_data_ok) begin
                    state_next = i_en_reg ? ST_I_REQ : ST_DONE;
                end
            end
            ST_I_REQ: begin
                req = !i_blocked;
                if (req && bus_addr_ok) begin
                    state_next = ST_I_WAIT;
                end
            end
            ST_I_WAIT: begin
                if (bus_data_ok) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            i_en_reg       <= 1'b0;
            i_addr_reg     <= 32'd0;
            d_wen_reg      <= 4'd0;
            d_addr_reg     <= 32'd0;
            d_wdata_reg    <= 32'd0;
            inst_rdata_reg <= 32'd0;
            data_rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            // The core holds its ports while stalled, so sampling only here is sufficient.
            if (capture) begin
                i_en_reg    <= inst_sram_en;
                i_addr_reg  <= inst_sram_addr;
                d_wen_reg   <= data_sram_wen;
                d_addr_reg  <= data_sram_addr;
                d_wdata_reg <= data_sram_wdata;
            end
            if ((state_reg == ST_D_WAIT) && bus_data_ok && !d_is_write) begin
                data_rdata_reg <= bus_rdata;
            end
            if ((state_reg == ST_I_WAIT) && bus_data_ok) begin
                inst_rdata_reg <= bus_rdata;
            end
        end
    end

    bridge_req_mux u_req_mux (
        .active     (req),
        .sel_data   (sel_data),
        .data_wen   (d_wen_reg),
        .data_addr  (d_addr_reg),
        .data_wdata (d_wdata_reg),
        .inst_addr  (i_addr_reg),
        .bus_wr     (bus_wr),
        .bus_size   (bus_size),
        .bus_wstrb  (bus_wstrb),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata)
    );

    assign bus_req         = req;
    assign stall_req       = capture ? (inst_sram_en | data_sram_en) : 1'b1;
    assign inst_sram_rdata = inst_rdata_reg;
    assign data_sram_rdata = data_rdata_reg;

endmodule
